// File: rtl/instr_axil_loader_if.sv
// AXI4-Lite write-channel bundle between the host interconnect and the instruction loader.
interface instr_axil_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;

    modport slave (
        input  s_awaddr,
        input  s_awvalid,
        output s_awready,
        input  s_wdata,
        input  s_wstrb,
        input  s_wvalid,
        output s_wready,
        output s_bresp,
        output s_bvalid,
        input  s_bready
    );

    modport master (
        output s_awaddr,
        output s_awvalid,
        input  s_awready,
        output s_wdata,
        output s_wstrb,
        output s_wvalid,
        input  s_wready,
        input  s_bresp,
        input  s_bvalid,
        output s_bready
    );
endinterface

// File: rtl/instr_axil_loader.sv
// AXI4-Lite write-only slave that loads the instruction store and owns the program-done bit.
// One transaction in flight: capture AW/W in any order, decode in WRITE, respond in RESP.
module instr_axil_loader #(
    parameter int unsigned N      = 512,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   clk,
    input  logic                   rstn,
    instr_axil_loader_if.slave     axil,
    output logic                   mem_we,
    output logic [$clog2(N)-1:0]   mem_waddr,
    output logic [31:0]            mem_wdata,
    output logic                   prog_done,
    output logic [15:0]            wr_count
);
    localparam int unsigned       IDX_W       = $clog2(N);
    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(N * 4);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {StIdle, StWrite, StResp} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic              aw_full_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              w_full_q;
    logic              aw_ready_q;
    logic              w_ready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [1:0]        resp_q;
    logic              mem_we_q;
    logic              ctrl_we_q;
    logic              ctrl_bit_q;
    logic [IDX_W-1:0]  mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              prog_done_q;
    logic [15:0]       wr_count_q;

    logic              aw_cap;
    logic              w_cap;
    logic              aw_full_n;
    logic              w_full_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       data_n;
    logic [3:0]        strb_n;
    logic              is_instr;
    logic              is_ctrl;
    logic [1:0]        resp_n;

    // Decode the request as it will look once both holding registers are full, so the
    // WRITE-cycle outputs can be registered on entry.
    always_comb begin
        aw_cap    = axil.s_awvalid && aw_ready_q;
        w_cap     = axil.s_wvalid && w_ready_q;
        aw_full_n = aw_full_q || aw_cap;
        w_full_n  = w_full_q || w_cap;
        addr_n    = aw_full_q ? aw_addr_q : axil.s_awaddr;
        data_n    = w_full_q ? w_data_q : axil.s_wdata;
        strb_n    = w_full_q ? w_strb_q : axil.s_wstrb;
        is_instr  = addr_n < CTRL_ADDR;
        is_ctrl   = addr_n == CTRL_ADDR;
        resp_n    = RESP_OKAY;
        if (addr_n[1:0] != 2'b00) begin
            resp_n = RESP_SLVERR;
        end else if (addr_n > CTRL_ADDR) begin
            resp_n = RESP_DECERR;
        end else if (strb_n != 4'hF) begin
            resp_n = RESP_SLVERR;
        end else if (is_instr && prog_done_q) begin
            resp_n = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            aw_addr_q   <= '0;
            aw_full_q   <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            w_full_q    <= 1'b0;
            aw_ready_q  <= 1'b0;
            w_ready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            resp_q      <= RESP_OKAY;
            mem_we_q    <= 1'b0;
            ctrl_we_q   <= 1'b0;
            ctrl_bit_q  <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            prog_done_q <= 1'b0;
            wr_count_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (aw_cap) begin
                        aw_addr_q <= axil.s_awaddr;
                        aw_full_q <= 1'b1;
                    end
                    if (w_cap) begin
                        w_data_q  <= axil.s_wdata;
                        w_strb_q  <= axil.s_wstrb;
                        w_full_q  <= 1'b1;
                    end
                    if (aw_full_n && w_full_n) begin
                        state_q     <= StWrite;
                        aw_ready_q  <= 1'b0;
                        w_ready_q   <= 1'b0;
                        resp_q      <= resp_n;
                        mem_we_q    <= (resp_n == RESP_OKAY) && is_instr;
                        ctrl_we_q   <= (resp_n == RESP_OKAY) && is_ctrl;
                        ctrl_bit_q  <= data_n[0];
                        mem_waddr_q <= addr_n[IDX_W+1:2];
                        mem_wdata_q <= data_n;
                    end else begin
                        aw_ready_q  <= !aw_full_n;
                        w_ready_q   <= !w_full_n;
                    end
                end
                StWrite: begin
                    mem_we_q  <= 1'b0;
                    ctrl_we_q <= 1'b0;
                    if (ctrl_we_q) begin
                        prog_done_q <= ctrl_bit_q;
                    end
                    if (mem_we_q && (wr_count_q != 16'hFFFF)) begin
                        wr_count_q <= wr_count_q + 16'd1;
                    end
                    bresp_q   <= resp_q;
                    bvalid_q  <= 1'b1;
                    aw_full_q <= 1'b0;
                    w_full_q  <= 1'b0;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (axil.s_bready) begin
                        bvalid_q   <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign axil.s_awready = aw_ready_q;
    assign axil.s_wready  = w_ready_q;
    assign axil.s_bvalid  = bvalid_q;
    assign axil.s_bresp   = bresp_q;
    // A reset landing on the WRITE cycle must suppress the store write already registered.
    assign mem_we         = mem_we_q && rstn;
    assign mem_waddr      = mem_waddr_q;
    assign mem_wdata      = mem_wdata_q;
    assign prog_done      = prog_done_q;
    assign wr_count       = wr_count_q;
endmodule

// File: tb/tb_instr_axil_loader.sv
// Bench for instr_axil_loader: directed steps plus random writes scored against a
// behavioural model of the address map, response rules, program-done bit and write counter.
module tb_instr_axil_loader;
    localparam int CTRL = 2048;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        prog_done;
    logic [15:0] wr_count;

    instr_axil_loader_if #(.ADDR_W(12)) axil ();

    instr_axil_loader #(.N(512), .ADDR_W(12)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .axil      (axil),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .prog_done (prog_done),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int m_cnt = 0;
    logic m_pd = 1'b0;

    int          we_cyc_q[$];
    logic [8:0]  we_addr_q[$];
    logic [31:0] we_data_q[$];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            we_cyc_q.push_back(cyc_cnt);
            we_addr_q.push_back(mem_waddr);
            we_data_q.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_resp(input int a, input logic [3:0] s, input logic pd);
        if (a % 4 != 0) return 2'b10;
        if (a > CTRL) return 2'b11;
        if (s != 4'hF) return 2'b10;
        if (a < CTRL && pd) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void clear_mon();
        we_cyc_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
    endfunction

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly);
        bit aw_done = 0, w_done = 0, b_done = 0, bv_seen = 0;
        int n = 0, bheld = 0, hs_cyc = 0, bv_cyc = 0;
        logic [1:0] resp_first = 2'bxx;
        logic [1:0] exp_resp;
        bit exp_we;
        exp_resp = model_resp(int'(addr), strb, m_pd);
        exp_we = (exp_resp == 2'b00) && (int'(addr) < CTRL);
        clear_mon();
        while (!b_done && n < 60) begin
            @(negedge clk);
            if (aw_done) check("awready_low", axil.s_awready, 0);
            if (w_done) check("wready_low", axil.s_wready, 0);
            if (axil.s_bvalid) begin
                if (!bv_seen) begin
                    bv_seen = 1;
                    bv_cyc = cyc_cnt;
                    resp_first = axil.s_bresp;
                end else begin
                    check("bresp_stable", axil.s_bresp, resp_first);
                end
            end
            axil.s_awaddr  = addr;
            axil.s_wdata   = data;
            axil.s_wstrb   = strb;
            axil.s_awvalid = !aw_done && n >= aw_dly;
            axil.s_wvalid  = !w_done && n >= w_dly;
            axil.s_bready  = bv_seen && bheld >= b_dly;
            if (axil.s_awvalid && axil.s_awready) begin
                aw_done = 1;
                if (cyc_cnt + 1 > hs_cyc) hs_cyc = cyc_cnt + 1;
            end
            if (axil.s_wvalid && axil.s_wready) begin
                w_done = 1;
                if (cyc_cnt + 1 > hs_cyc) hs_cyc = cyc_cnt + 1;
            end
            if (axil.s_bvalid && axil.s_bready) b_done = 1;
            else if (axil.s_bvalid) bheld++;
            n++;
        end
        check("b_handshake_done", 32'(b_done), 1);
        @(negedge clk);
        axil.s_awvalid = 1'b0;
        axil.s_wvalid  = 1'b0;
        axil.s_bready  = 1'b0;
        check("awready_back", axil.s_awready, 1);
        check("wready_back", axil.s_wready, 1);
        check("bresp", resp_first, exp_resp);
        check("bvalid_latency", bv_cyc, hs_cyc + 1);
        check("mem_we_pulses", we_cyc_q.size(), 32'(exp_we));
        if (exp_we && we_cyc_q.size() == 1) begin
            check("mem_waddr", we_addr_q[0], int'(addr) / 4);
            check("mem_wdata", we_data_q[0], data);
            check("mem_we_cycle", we_cyc_q[0], hs_cyc);
        end
        if (exp_resp == 2'b00) begin
            if (int'(addr) < CTRL) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            else m_pd = data[0];
        end
        check("wr_count", wr_count, m_cnt);
        check("prog_done", prog_done, m_pd);
    endtask

    initial begin
        logic [11:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        rstn = 1'b0;
        axil.s_awaddr = '0;
        axil.s_awvalid = 1'b0;
        axil.s_wdata = '0;
        axil.s_wstrb = '0;
        axil.s_wvalid = 1'b0;
        axil.s_bready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", axil.s_awready, 0);
        check("rst_wready", axil.s_wready, 0);
        check("rst_bvalid", axil.s_bvalid, 0);
        check("rst_bresp", axil.s_bresp, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_waddr", mem_waddr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_prog_done", prog_done, 0);
        check("rst_wr_count", wr_count, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_awready", axil.s_awready, 1);
        check("post_rst_wready", axil.s_wready, 1);

        // Same-cycle AW/W, then W leading AW with a slow B channel.
        do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(12'h7FC, 32'hCAFEF00D, 4'hF, 3, 0, 4);

        // Error responses.
        do_write(12'h006, 32'h11111111, 4'hF, 0, 0, 0);
        do_write(12'h804, 32'h22222222, 4'hF, 0, 1, 0);
        do_write(12'h010, 32'h33333333, 4'h3, 1, 0, 0);

        // Program-done write protection.
        do_write(12'h800, 32'h00000001, 4'hF, 0, 0, 0);
        do_write(12'h000, 32'h44444444, 4'hF, 0, 0, 0);
        do_write(12'h800, 32'h00000000, 4'hF, 0, 0, 0);
        do_write(12'h000, 32'h55555555, 4'hF, 0, 0, 1);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 12'($urandom_range(0, 511) * 4);
                6:                a = 12'h800;
                7:                a = 12'($urandom_range(0, 511) * 4 + $urandom_range(1, 3));
                8:                a = 12'($urandom_range(513, 1023) * 4);
                default:          a = 12'($urandom_range(0, 4095));
            endcase
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            d = $urandom;
            do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Make sure there is state to lose, then reset during the WRITE cycle.
        do_write(12'h800, 32'h00000000, 4'hF, 0, 0, 0);
        do_write(12'h020, 32'h0BADF00D, 4'hF, 0, 0, 0);
        clear_mon();
        @(negedge clk);
        axil.s_awaddr = 12'h010;
        axil.s_wdata = 32'h12345678;
        axil.s_wstrb = 4'hF;
        axil.s_awvalid = 1'b1;
        axil.s_wvalid = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        axil.s_awvalid = 1'b0;
        axil.s_wvalid = 1'b0;
        @(negedge clk);
        check("midrst_mem_we", mem_we, 0);
        @(negedge clk);
        check("midrst_bvalid", axil.s_bvalid, 0);
        check("midrst_bresp", axil.s_bresp, 0);
        check("midrst_mem_waddr", mem_waddr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_prog_done", prog_done, 0);
        check("midrst_wr_count", wr_count, 0);
        check("midrst_awready", axil.s_awready, 0);
        check("midrst_wready", axil.s_wready, 0);
        m_cnt = 0;
        m_pd = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_ready_back", {axil.s_awready, axil.s_wready}, 2'b11);
        @(negedge clk);
        check("midrst_no_bvalid", axil.s_bvalid, 0);
        check("midrst_no_we", we_cyc_q.size(), 0);
        do_write(12'h014, 32'h87654321, 4'hF, 0, 0, 0);

        // Counter saturation: preload near the top instead of 65k real writes.
        @(negedge clk);
        force dut.wr_count_q = 16'hFFFD;
        #1;
        release dut.wr_count_q;
        m_cnt = 16'hFFFD;
        do_write(12'h100, 32'hA0A0A0A0, 4'hF, 0, 0, 0);
        do_write(12'h104, 32'hB0B0B0B0, 4'hF, 1, 0, 0);
        do_write(12'h108, 32'hC0C0C0C0, 4'hF, 0, 1, 0);
        do_write(12'h10C, 32'hD0D0D0D0, 4'hF, 0, 0, 2);
        check("sat_final", wr_count, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
